// File: rtl/debug_reg_dump_if.sv
// Bundle between the debug dumper, the register bank debug read port and the UART TX.
// master = dumper side, slave = bank/UART side.
interface debug_reg_dump_if #(
  parameter int BITS_SIZE = 32,
  parameter int BITS_REGS = 5,
  parameter int BITS_BYTE = 8
);
  logic                 i_start;
  logic [BITS_SIZE-1:0] i_reg_data;
  logic                 i_tx_done;
  logic [BITS_REGS-1:0] o_addr_reg_unitdebug;
  logic                 o_tx_start;
  logic [BITS_BYTE-1:0] o_tx_data;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    input  i_start, i_reg_data, i_tx_done,
    output o_addr_reg_unitdebug, o_tx_start, o_tx_data, o_busy, o_done
  );

  modport slave (
    output i_start, i_reg_data, i_tx_done,
    input  o_addr_reg_unitdebug, o_tx_start, o_tx_data, o_busy, o_done
  );
endinterface

// File: rtl/debug_reg_dump.sv
// Walks the register bank debug port and streams every word to the UART TX,
// least significant byte first, one byte per tx_start/tx_done handshake.
module debug_reg_dump #(
  parameter int BITS_SIZE = 32,
  parameter int BITS_REGS = 5,
  parameter int REG_SIZE  = 32,
  parameter int BITS_BYTE = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  debug_reg_dump_if.master bus
);
  localparam int BYTES = BITS_SIZE / BITS_BYTE;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0]       LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [BCW-1:0]       BYTE_ONE  = BCW'(1);
  localparam logic [BITS_REGS-1:0] LAST_ADDR = BITS_REGS'(REG_SIZE - 1);
  localparam logic [BITS_REGS-1:0] ADDR_ONE  = BITS_REGS'(1);

  typedef enum logic [2:0] {IDLE, LATCH, SEND, WAIT, DONE} state_t;

  state_t                          state, state_d;
  logic [BITS_REGS-1:0]            addr, addr_d;
  logic [BCW-1:0]                  byte_cnt, byte_cnt_d;
  logic [BYTES-1:0][BITS_BYTE-1:0] latch_q, latch_d;
  logic [BYTES-1:0][BITS_BYTE-1:0] reg_bytes;
  logic                            tx_start, tx_start_d;
  logic [BITS_BYTE-1:0]            tx_data, tx_data_d;
  logic                            busy, busy_d;
  logic                            done, done_d;

  assign reg_bytes = bus.i_reg_data;

  // Outputs are computed for the state being entered and registered with it,
  // so tx_start is high exactly while SEND is the current state and done
  // exactly while DONE is.
  always_comb begin
    state_d    = state;
    addr_d     = addr;
    byte_cnt_d = byte_cnt;
    latch_d    = latch_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    done_d     = 1'b0;

    case (state)
      IDLE: begin
        if (bus.i_start) begin
          addr_d     = '0;
          byte_cnt_d = '0;
          state_d    = LATCH;
        end
      end
      LATCH: begin
        // Address has been on the port since the previous edge; read is settled.
        latch_d    = reg_bytes;
        tx_start_d = 1'b1;
        tx_data_d  = reg_bytes[byte_cnt];
        state_d    = SEND;
      end
      SEND: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.i_tx_done) begin
          if (byte_cnt != LAST_BYTE) begin
            byte_cnt_d = byte_cnt + BYTE_ONE;
            tx_start_d = 1'b1;
            tx_data_d  = latch_q[byte_cnt + BYTE_ONE];
            state_d    = SEND;
          end else if (addr != LAST_ADDR) begin
            addr_d     = addr + ADDR_ONE;
            byte_cnt_d = '0;
            state_d    = LATCH;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        addr_d  = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state    <= IDLE;
      addr     <= '0;
      byte_cnt <= '0;
      latch_q  <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      addr     <= addr_d;
      byte_cnt <= byte_cnt_d;
      latch_q  <= latch_d;
      tx_start <= tx_start_d;
      tx_data  <= tx_data_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  assign bus.o_addr_reg_unitdebug = addr;
  assign bus.o_tx_start           = tx_start;
  assign bus.o_tx_data            = tx_data;
  assign bus.o_busy               = busy;
  assign bus.o_done               = done;
endmodule

// File: tb/tb_debug_reg_dump.sv
// Directed bench for debug_reg_dump: bank array model plus a UART TX model
// that answers each tx_start with tx_done after a programmable delay.
module tb_debug_reg_dump;
  localparam int BITS_SIZE = 32;
  localparam int BITS_REGS = 5;
  localparam int REG_SIZE  = 32;
  localparam int BITS_BYTE = 8;
  localparam int NBYTES    = REG_SIZE * (BITS_SIZE / BITS_BYTE);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  debug_reg_dump_if #(.BITS_SIZE(BITS_SIZE), .BITS_REGS(BITS_REGS), .BITS_BYTE(BITS_BYTE)) bus ();

  debug_reg_dump #(
    .BITS_SIZE(BITS_SIZE), .BITS_REGS(BITS_REGS), .REG_SIZE(REG_SIZE), .BITS_BYTE(BITS_BYTE)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.master)
  );

  logic [BITS_SIZE-1:0] bank [REG_SIZE];
  assign bus.i_reg_data = bank[bus.o_addr_reg_unitdebug];

  int checks = 0;
  int errors = 0;

  logic [7:0] cap_q[$];
  logic [4:0] cap_addr_q[$];
  int dones    = 0;
  int cnt      = 0;
  int tx_delay = 10;
  int inj_at   = -1;
  int stall_at = -1;

  // UART TX model and capture monitor.
  always @(negedge clk) begin
    bus.i_tx_done = 1'b0;
    if (!rst) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.i_tx_done = 1'b1;
      end
      if (bus.o_tx_start) begin
        cap_q.push_back(bus.o_tx_data);
        cap_addr_q.push_back(bus.o_addr_reg_unitdebug);
        cnt = (cap_q.size() - 1 == stall_at) ? 1000 : tx_delay;
        if (cap_q.size() - 1 == inj_at) bus.i_tx_done = 1'b1;
      end
      if (bus.o_done) dones++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic fill_bank();
    for (int n = 0; n < REG_SIZE; n++) bank[n] = 32'(n) * 32'h0101_0101;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (cap_q.size() >= n) begin ok = 1'b1; break; end
      step();
    end
  endtask

  // Waits for o_done and checks busy falls in the following cycle.
  task automatic finish_dump(input string name, input int base, input int dbase);
    bit seen = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (bus.o_done) begin seen = 1'b1; break; end
      step();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: o_done never seen, bytes=%0d required %0d", name, cap_q.size() - base, NBYTES);
    end
    checks++;
    if (bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_in_done: got %b required 1", name, bus.o_busy);
    end
    step();
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after_done: busy=%b done=%b required 0 0", name, bus.o_busy, bus.o_done);
    end
    repeat (30) step();
    checks++;
    if (cap_q.size() - base != NBYTES) begin
      errors++;
      $display("FAIL %s pulse_count: got %0d required %0d", name, cap_q.size() - base, NBYTES);
    end
    checks++;
    if (dones - dbase != 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d required 1", name, dones - dbase);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.i_start = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.o_addr_reg_unitdebug !== 5'd0 || bus.o_tx_start !== 1'b0 || bus.o_tx_data !== 8'd0 ||
        bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%0d txs=%b data=%h busy=%b done=%b required all 0",
               bus.o_addr_reg_unitdebug, bus.o_tx_start, bus.o_tx_data, bus.o_busy, bus.o_done);
    end
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_without_start: busy=%b required 0", bus.o_busy);
    end
  endtask

  task automatic test_full_dump();
    int base = cap_q.size();
    int dbase = dones;
    fill_bank();
    pulse_start();
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_tx_start !== 1'b0) begin
      errors++;
      $display("FAIL latch_cycle: busy=%b txs=%b required 1 0", bus.o_busy, bus.o_tx_start);
    end
    step();
    checks++;
    if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== 8'h00 || bus.o_addr_reg_unitdebug !== 5'd0) begin
      errors++;
      $display("FAIL first_send: txs=%b data=%h addr=%0d required 1 00 0",
               bus.o_tx_start, bus.o_tx_data, bus.o_addr_reg_unitdebug);
    end
    finish_dump("full", base, dbase);
    for (int k = 0; k < NBYTES; k++) begin
      checks++;
      if (cap_q[base + k] !== 8'(k / 4)) begin
        errors++;
        $display("FAIL full_byte[%0d]: got %h required %h", k, cap_q[base + k], 8'(k / 4));
      end
    end
  endtask

  task automatic test_byte_order();
    int base = cap_q.size();
    int dbase = dones;
    logic [7:0] exp_r1 [4];
    logic [7:0] exp_r31 [4];
    exp_r1  = '{8'h44, 8'h33, 8'h22, 8'h11};
    exp_r31 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    fill_bank();
    bank[1]  = 32'h1122_3344;
    bank[31] = 32'hDEAD_BEEF;
    pulse_start();
    finish_dump("order", base, dbase);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (cap_q[base + 4 + b] !== exp_r1[b] || cap_addr_q[base + 4 + b] !== 5'd1) begin
        errors++;
        $display("FAIL order_r1[%0d]: byte=%h addr=%0d required %h 1", b,
                 cap_q[base + 4 + b], cap_addr_q[base + 4 + b], exp_r1[b]);
      end
      checks++;
      if (cap_q[base + 124 + b] !== exp_r31[b] || cap_addr_q[base + 124 + b] !== 5'd31) begin
        errors++;
        $display("FAIL order_r31[%0d]: byte=%h addr=%0d required %h 31", b,
                 cap_q[base + 124 + b], cap_addr_q[base + 124 + b], exp_r31[b]);
      end
    end
  endtask

  task automatic test_ignored_inputs();
    int base = cap_q.size();
    int dbase = dones;
    bit ok;
    fill_bank();
    inj_at = base + 5;
    pulse_start();
    wait_bytes(base + 20, ok);
    step();
    pulse_start();
    finish_dump("ignore", base, dbase);
    inj_at = -1;
    for (int k = 0; k < NBYTES; k++) begin
      checks++;
      if (cap_q[base + k] !== 8'(k / 4)) begin
        errors++;
        $display("FAIL ignore_byte[%0d]: got %h required %h", k, cap_q[base + k], 8'(k / 4));
      end
    end
  endtask

  task automatic test_snapshot();
    int base = cap_q.size();
    int dbase = dones;
    bit ok;
    fill_bank();
    pulse_start();
    wait_bytes(base + 10, ok);
    bank[2] = 32'hFFFF_FFFF;
    bank[5] = 32'hA5A5_A5A5;
    finish_dump("snap", base, dbase);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (cap_q[base + 8 + b] !== 8'h02) begin
        errors++;
        $display("FAIL snap_r2[%0d]: got %h required 02", b, cap_q[base + 8 + b]);
      end
      checks++;
      if (cap_q[base + 20 + b] !== 8'hA5) begin
        errors++;
        $display("FAIL snap_r5[%0d]: got %h required a5", b, cap_q[base + 20 + b]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int base = cap_q.size();
    int dbase = dones;
    int base2;
    bit ok;
    fill_bank();
    pulse_start();
    wait_bytes(base + 10, ok);
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++;
    if (bus.o_addr_reg_unitdebug !== 5'd0 || bus.o_tx_start !== 1'b0 || bus.o_tx_data !== 8'd0 ||
        bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: addr=%0d txs=%b data=%h busy=%b done=%b required all 0",
               bus.o_addr_reg_unitdebug, bus.o_tx_start, bus.o_tx_data, bus.o_busy, bus.o_done);
    end
    repeat (100) step();
    checks++;
    if (cap_q.size() - base != 10 || dones != dbase || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: bytes=%0d dones=%0d busy=%b required 10 0 0",
               cap_q.size() - base, dones - dbase, bus.o_busy);
    end
    base2 = cap_q.size();
    pulse_start();
    finish_dump("restart", base2, dbase);
    for (int k = 0; k < NBYTES; k++) begin
      checks++;
      if (cap_q[base2 + k] !== 8'(k / 4) || cap_addr_q[base2 + k] !== 5'(k / 4)) begin
        errors++;
        $display("FAIL restart_byte[%0d]: byte=%h addr=%0d required %h %0d", k,
                 cap_q[base2 + k], cap_addr_q[base2 + k], 8'(k / 4), k / 4);
      end
    end
  endtask

  task automatic test_stall();
    int base = cap_q.size();
    int dbase = dones;
    int bad = 0;
    bit ok;
    fill_bank();
    stall_at = base + 7;
    pulse_start();
    wait_bytes(base + 8, ok);
    step();
    for (int c = 0; c < 990; c++) begin
      if (bus.o_busy !== 1'b1 || bus.o_tx_start !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0 || cap_q.size() - base != 8) begin
      errors++;
      $display("FAIL stall_hold: bad_cycles=%0d bytes=%0d required 0 8", bad, cap_q.size() - base);
    end
    finish_dump("stall", base, dbase);
    stall_at = -1;
    for (int k = 0; k < NBYTES; k++) begin
      checks++;
      if (cap_q[base + k] !== 8'(k / 4)) begin
        errors++;
        $display("FAIL stall_byte[%0d]: got %h required %h", k, cap_q[base + k], 8'(k / 4));
      end
    end
  endtask

  initial begin
    bus.i_start = 1'b0;
    fill_bank();
    test_reset();
    test_full_dump();
    test_byte_order();
    test_ignored_inputs();
    test_snapshot();
    test_reset_abort();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
